imem_fetch_resp: RTL and testbench
==================================

# imem_fetch_resp

Instruction-memory responder for the fetch path: accepts an instruction address from the PC/fetch side over a valid/ready request channel, waits a programmable number of cycles, and returns the 32-bit instruction word (or a NOP plus error flag) over a valid/ready response channel. It sits between the PC register and the decode stage and replaces the zero-latency combinational ROM when multi-cycle fetch is modelled. A write-only preload port lets the bench or boot logic fill the array.

## Interface

- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array (1024 words = 4 KiB)
- LATENCY, 2, wait cycles between request acceptance and response (0..15)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request present
- req_addr  in  32  byte address of the instruction
- req_ready  out  1  responder can accept a request
- rsp_valid  out  1  response word present
- rsp_ready  in  1  consumer takes the response
- rsp_inst  out  32  fetched instruction word
- rsp_err  out  1  request was misaligned or out of range
- ld_en  in  1  preload write enable
- ld_addr  in  DEPTH_LOG2  preload word index
- ld_data  in  32  preload word

## Operation

- One clock domain; reset asynchronous, active-low (rst_n); no synchronous reset path.
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready=1, rsp_valid=0. On req_valid && req_ready: latch req_addr; next state WAIT with wait counter=LATENCY if LATENCY>0, else RESP.
- WAIT: req_ready=0, rsp_valid=0; counter decrements each cycle; on the edge where counter==1, go to RESP.
- Entering RESP (register load on that edge): if req_addr[1:0]!=0 or req_addr[31:2] >= 2**DEPTH_LOG2: rsp_inst=32'h0000_0013 (addi x0,x0,0), rsp_err=1; else rsp_inst=mem[req_addr[DEPTH_LOG2+1:2]], rsp_err=0. Misalignment has priority; both conditions give one err flag.
- RESP: rsp_valid=1, req_ready=0; rsp_inst/rsp_err held stable until rsp_valid && rsp_ready, then next state IDLE. No request is accepted in the handshake cycle (one bubble per fetch).
- Preload: ld_en writes mem[ld_addr]=ld_data on rising edge in any state. A write to the word being read on the same edge that enters RESP returns the old word (read-before-write). Array contents are not cleared by reset.
- Reset outputs: req_ready=1 after reset release (0 while rst_n low), rsp_valid=0, rsp_inst=32'h0000_0000, rsp_err=0, counter=0.
- Reset mid-transaction: pending request discarded, no response issued; returns to IDLE.
- req_addr/req_valid changes while not in IDLE are ignored.

## Timing

- Request accepted on edge T (req_valid && req_ready high before T): rsp_valid rises after edge T+LATENCY+1... precisely: high during the cycle following edge T+LATENCY (LATENCY=0: cycle after T).
- Minimum fetch period: LATENCY+2 cycles (accept, LATENCY waits, response, return to IDLE overlapped with handshake edge) when rsp_ready held high.
- Backpressure: rsp_ready low holds RESP indefinitely; outputs must not glitch or change.
- All outputs registered or decoded from registered state only; no combinational path from req_* or rsp_ready to any output.

## Test plan

- Reset: rst_n low asynchronously mid-WAIT -> rsp_valid=0, rsp_inst=0, rsp_err=0 immediately; after release req_ready=1, no stale response appears.
- Basic fetch, LATENCY=2: preload mem[3]=32'h0010_0093, request addr 32'h0000_000C, rsp_ready=1 -> rsp_valid high exactly 3 cycles after accept edge, rsp_inst=32'h0010_0093, rsp_err=0, req_ready back high next cycle.
- Backpressure: same fetch with rsp_ready low for 5 cycles -> rsp_valid and rsp_inst=32'h0010_0093 stable all 5 cycles; single handshake when rsp_ready rises; new req_valid during RESP not accepted.
- Errors: addr 32'h0000_0006 -> rsp_inst=32'h0000_0013, rsp_err=1; addr 32'h0000_1000 (DEPTH_LOG2=10) -> rsp_inst=32'h0000_0013, rsp_err=1.
- Preload collision: write mem[5]=32'hDEAD_BEEF on the RESP-entry edge of a fetch of 32'h14 whose old value is 32'h0000_0033 -> response 32'h0000_0033; a following fetch of 32'h14 returns 32'hDEAD_BEEF.
- LATENCY=0 back-to-back: 4 sequential fetches 0x0,0x4,0x8,0xC with rsp_ready=1 -> each response one cycle after accept, words in order, one bubble between fetches.

Source files
------------

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp
//   Multi-cycle instruction-memory responder for the fetch path. A fetch
//   request (byte address) is accepted over a valid/ready channel. After
//   LATENCY wait cycles the instruction word is returned over a valid/ready
//   response channel. A misaligned or out-of-range address returns a NOP
//   (addi x0,x0,0) with rsp_err set. A write-only preload port fills the
//   array in any state.
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit words in the array
//   LATENCY     wait cycles between accept and response (0..15)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready     response handshake, rsp_inst/rsp_err = payload
//   ld_en/ld_addr/ld_data   preload write port (word index)
module imem_fetch_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam logic [3:0]  LAT     = 4'(LATENCY);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  // Byte-address bits above the array; any of them set means out of range.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  rsp_t        rsp_q, rsp_d;
  logic        load;

  logic [31:0] mem_q [2**DEPTH_LOG2];

  // Address used for the lookup on the RESP-entry edge. With LATENCY=0 that
  // edge is the accept edge itself, so the live request address is used.
  logic [31:0]           rd_addr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_bad;

  assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign rd_idx  = rd_addr[DEPTH_LOG2+1:2];
  assign rd_bad  = (rd_addr[1:0] != 2'b00) || ((rd_addr & HI_MASK) != 32'd0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 0) begin
            state_d = RESP;
            load    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // cnt_q<=1 also guards against a zero count stalling in WAIT
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          load    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload is captured once on RESP entry and held until handshake.
  always_comb begin
    rsp_d = rsp_q;
    if (load) begin
      if (rd_bad) begin
        rsp_d.inst = NOP;
        rsp_d.err  = 1'b1;
      end else begin
        rsp_d.inst = mem_q[rd_idx];
        rsp_d.err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rsp_q   <= rsp_d;
    end
  end

  // Array is not reset. The read above samples the pre-edge contents, so a
  // preload to the same word on the RESP-entry edge returns the old word.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

  // req_ready is held low while reset is asserted.
  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = rsp_q.inst;
  assign rsp_err   = rsp_q.err;

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_inst) && $stable(rsp_err)));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid && req_ready));

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Scoreboard bench for imem_fetch_resp: instance 0 uses LATENCY=2, instance 1
// uses LATENCY=0. Expected responses come from a word-array model and are
// queued at issue; a per-instance monitor pops and compares on the DUT side.
module tb_imem_fetch_resp;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_inst;
  logic [1:0]       rsp_err;
  logic [1:0]       ld_en;
  logic [1:0][9:0]  ld_addr;
  logic [1:0][31:0] ld_data;

  imem_fetch_resp #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  imem_fetch_resp #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          acc;   // cycle number of the accept edge
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mmem [2][1024];
  int          latv [2] = '{2, 0};
  int          rmode[2];        // 0: ready low, 1: ready high, 2: random
  logic [1:0]  pv;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // rsp_ready changes just after the rising edge, away from monitor sampling.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++)
      rsp_ready[k] = (rmode[k] == 2) ? (($urandom % 4) != 0) : (rmode[k] == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void push(int k, exp_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Reference: word array plus the alignment/range rules.
  function automatic exp_t model(int k, logic [31:0] a, int acc);
    exp_t e;
    e.acc = acc;
    if (a[1:0] != 2'b00 || a >= 32'h0000_1000) begin
      e.inst = 32'h0000_0013;
      e.err  = 1'b1;
    end else begin
      e.inst = mmem[k][a[11:2]];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(int k);
    exp_t e;
    if (!rst_n) begin
      pv[k] = 1'b0;
      return;
    end
    if (rsp_valid[k]) begin
      if (qsize(k) == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_rsp[%0d]: got unexpected response %h expected none", k, rsp_inst[k]);
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        if (!pv[k]) chk($sformatf("latency[%0d]", k), 32'(cyc - e.acc), 32'(latv[k]));
        chk($sformatf("inst[%0d]", k), rsp_inst[k], e.inst);
        chk($sformatf("err[%0d]", k), 32'(rsp_err[k]), 32'(e.err));
        if (rsp_ready[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
    pv[k] = rsp_valid[k];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic preload(int k, int idx, logic [31:0] d);
    @(negedge clk);
    ld_en[k]   = 1'b1;
    ld_addr[k] = idx[9:0];
    ld_data[k] = d;
    @(posedge clk);
    mmem[k][idx] = d;
    #1 ld_en[k] = 1'b0;
  endtask

  task automatic fetch(int k, logic [31:0] a, bit track, output int acc);
    int n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout[%0d]: got req_ready 0 expected 1", k);
    end
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    acc = cyc + 1;
    if (track) push(k, model(k, a, acc));
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
  endtask

  task automatic drain(int k);
    int n = 0;
    @(negedge clk);
    while ((qsize(k) != 0 || rsp_valid[k]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout[%0d]: got %0d pending expected 0", k, qsize(k));
    end
  endtask

  initial begin
    int a1, a2, a3, a4, n;
    logic [31:0] ra;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    ld_en     = '0;
    ld_addr   = '0;
    ld_data   = '0;
    rmode     = '{0, 0};
    pv        = '0;

    // Reset state
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready_low", 32'(req_ready[k]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rsp_inst", rsp_inst[k], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) preload(k, i, $urandom);
    preload(0, 3, 32'h0010_0093);
    preload(0, 5, 32'h0000_0033);

    // Basic fetch and minimum fetch period at LATENCY=2
    rmode[0] = 1;
    fetch(0, 32'h0000_000C, 1'b1, a1);
    fetch(0, 32'h0000_0010, 1'b1, a2);
    chk("period_l2", 32'(a2 - a1), 32'd4);
    drain(0);

    // Backpressure: hold RESP for 5 cycles while a new request is offered
    rmode[0] = 0;
    drain(0);
    fetch(0, 32'h0000_000C, 1'b1, a1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_resp", 32'(rsp_valid[0]), 32'd1);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_0010;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
      chk("bp_rsp_inst", rsp_inst[0], 32'h0010_0093);
    end
    req_valid[0] = 1'b0;
    rmode[0]     = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_after_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_after_ready", 32'(req_ready[0]), 32'd1);
    repeat (6) @(negedge clk);
    drain(0);

    // Error responses
    fetch(0, 32'h0000_0006, 1'b1, a1);
    fetch(0, 32'h0000_1000, 1'b1, a1);
    drain(0);

    // Preload collision on the RESP-entry edge
    fetch(0, 32'h0000_0014, 1'b1, a1);
    @(posedge clk);
    @(negedge clk);
    ld_en[0]   = 1'b1;
    ld_addr[0] = 10'd5;
    ld_data[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    mmem[0][5] = 32'hDEAD_BEEF;
    #1 ld_en[0] = 1'b0;
    drain(0);
    fetch(0, 32'h0000_0014, 1'b1, a1);
    drain(0);
    chk("collision_model", mmem[0][5], 32'hDEAD_BEEF);

    // LATENCY=0 back-to-back
    rmode[1] = 1;
    fetch(1, 32'h0, 1'b1, a1);
    fetch(1, 32'h4, 1'b1, a2);
    fetch(1, 32'h8, 1'b1, a3);
    fetch(1, 32'hC, 1'b1, a4);
    chk("period_l0_a", 32'(a2 - a1), 32'd2);
    chk("period_l0_b", 32'(a3 - a2), 32'd2);
    chk("period_l0_c", 32'(a4 - a3), 32'd2);
    drain(1);

    // Reset mid-WAIT after an error response left non-zero outputs
    fetch(0, 32'h0000_0006, 1'b1, a1);
    drain(0);
    fetch(0, 32'h0000_0008, 1'b0, a1);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("amid_rsp_inst", rsp_inst[0], 32'd0);
    chk("amid_rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("amid_req_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("amid_rel_ready", 32'(req_ready[0]), 32'd1);
    repeat (8) @(negedge clk);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 2; k++) begin
      rmode[k] = 2;
      for (int i = 0; i < 150; i++) begin
        case ($urandom % 10)
          0: begin
            drain(k);
            preload(k, int'($urandom_range(0, 63)), $urandom);
          end
          1: ra = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
          2: ra = $urandom | 32'h0000_1000;
          default: ra = $urandom_range(0, 63) << 2;
        endcase
        fetch(k, ra, 1'b1, a1);
      end
      drain(k);
      rmode[k] = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
